// File: rtl/uart_periph_if.sv
// uart_periph_if: native valid/ready CPU bus slice seen by the UART.
// master drives valid/enable/addr/wdata/wstrb; slave returns ready/rdata.
interface uart_periph_if;
  logic        mem_valid;
  logic        enable;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, enable, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, enable, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART with TX FIFO, RX holding reg, divisor.
// Ports: clk, reset (sync high), bus (slave), uart_tx, uart_rx, irq.
module uart_periph #(
  parameter int BAUD_DIV      = 434,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  uart_periph_if.slave bus,
  output logic         uart_tx,
  input  logic         uart_rx,
  output logic         irq
);
  localparam int AW = $clog2(TX_FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } st_t;

  logic [15:0] divisor, lat_clamped;
  logic        ready_q;
  logic [31:0] rdata_q, rd_val;
  logic        rx_valid, overrun;
  logic [7:0]  rx_byte;

  logic [7:0]  fifo [TX_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;

  logic        acc, wr, push_req, ack;
  logic        rd_clr, stat_wr, div_wr;
  logic [1:0]  sel;

  assign lat_clamped = (divisor < 16'd2) ? 16'd2 : divisor;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign sel      = bus.mem_addr[3:2];
  assign wr       = |bus.mem_wstrb;
  assign acc      = bus.mem_valid & bus.enable & ~ready_q;
  assign push_req = acc & wr & (sel == 2'd0) & bus.mem_wstrb[0];
  // A push into a full FIFO waits unless the TX side pops on this edge.
  assign ack      = acc & ~(push_req & full & ~pop);
  assign push     = push_req & ack;
  assign rd_clr   = ack & ~wr & (sel == 2'd0);
  assign stat_wr  = ack & wr & (sel == 2'd1);
  assign div_wr   = ack & wr & (sel == 2'd2);

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign irq           = rx_valid;

  logic unused;
  assign unused = ^{bus.mem_addr[1:0], bus.mem_wdata[31:16]};

  // TX state
  st_t         tx_st, tx_st_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_lat, tx_lat_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic        tx_n, tx_end, tx_go;

  // RX state
  st_t         rx_st, rx_st_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_lat, rx_lat_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic        rx_s1, rx_s2, rx_prev, rx_store;

  always_comb begin
    rd_val = 32'd0;
    unique case (1'b1)
      (sel == 2'd0): rd_val = {23'd0, rx_valid, rx_byte};
      (sel == 2'd1): rd_val = {27'd0, tx_st != S_IDLE, overrun,
                               rx_valid, empty, full};
      (sel == 2'd2): rd_val = {16'd0, divisor};
      default:       rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[AW-1:0]] <= bus.mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q  <= 1'b0;
      rdata_q  <= 32'd0;
      divisor  <= 16'(BAUD_DIV);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= 8'd0;
      overrun  <= 1'b0;
    end else begin
      ready_q <= ack;
      rdata_q <= (ack & ~wr) ? rd_val : 32'd0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (div_wr && bus.mem_wstrb[0]) divisor[7:0]  <= bus.mem_wdata[7:0];
      if (div_wr && bus.mem_wstrb[1]) divisor[15:8] <= bus.mem_wdata[15:8];
      if (stat_wr) overrun <= 1'b0;
      // A store coinciding with the read-clear keeps rx_valid set.
      if (rx_store) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_clr) overrun <= 1'b1;
      end else if (rd_clr) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign tx_end = (tx_cnt == tx_lat - 16'd1);

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt + 16'd1;
    tx_lat_n = tx_lat;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_go    = 1'b0;
    unique case (tx_st)
      S_IDLE: tx_go = ~empty;
      S_START: if (tx_end) begin
        tx_cnt_n = 16'd0;
        tx_st_n  = S_DATA;
      end
      S_DATA: if (tx_end) begin
        tx_cnt_n = 16'd0;
        tx_sh_n  = {1'b0, tx_sh[7:1]};
        tx_bit_n = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_st_n = S_STOP;
      end
      S_STOP: if (tx_end) begin
        tx_go   = ~empty;
        tx_st_n = S_IDLE;
      end
      default: tx_st_n = S_IDLE;
    endcase
    if (tx_go) begin
      tx_st_n  = S_START;
      tx_cnt_n = 16'd0;
      tx_bit_n = 3'd0;
      tx_lat_n = lat_clamped;
      tx_sh_n  = fifo[rd_ptr[AW-1:0]];
    end
    pop  = tx_go;
    tx_n = (tx_st_n == S_START) ? 1'b0 :
           (tx_st_n == S_DATA)  ? tx_sh_n[0] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st   <= S_IDLE;
      tx_cnt  <= 16'd0;
      tx_lat  <= 16'd2;
      tx_bit  <= 3'd0;
      tx_sh   <= 8'd0;
      uart_tx <= 1'b1;
    end else begin
      tx_st   <= tx_st_n;
      tx_cnt  <= tx_cnt_n;
      tx_lat  <= tx_lat_n;
      tx_bit  <= tx_bit_n;
      tx_sh   <= tx_sh_n;
      uart_tx <= tx_n;
    end
  end

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt + 16'd1;
    rx_lat_n = rx_lat;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_store = 1'b0;
    unique case (rx_st)
      S_IDLE: if (rx_prev && !rx_s2) begin
        rx_st_n  = S_START;
        rx_cnt_n = 16'd0;
        rx_lat_n = lat_clamped;
      end
      S_START: if (rx_cnt == (rx_lat >> 1) - 16'd1) begin
        rx_cnt_n = 16'd0;
        rx_bit_n = 3'd0;
        rx_st_n  = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt == rx_lat - 16'd1) begin
        rx_cnt_n = 16'd0;
        rx_sh_n  = {rx_s2, rx_sh[7:1]};
        rx_bit_n = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_st_n = S_STOP;
      end
      S_STOP: if (rx_cnt == rx_lat - 16'd1) begin
        rx_st_n  = S_IDLE;
        rx_store = rx_s2;
      end
      default: rx_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= S_IDLE;
      rx_cnt  <= 16'd0;
      rx_lat  <= 16'd2;
      rx_bit  <= 3'd0;
      rx_sh   <= 8'd0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_st   <= rx_st_n;
      rx_cnt  <= rx_cnt_n;
      rx_lat  <= rx_lat_n;
      rx_bit  <= rx_bit_n;
      rx_sh   <= rx_sh_n;
    end
  end
endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: directed + randomized bench for uart_periph.
// Bus driven through uart_periph_if; serial lines modelled as 8N1 frames.
module tb_uart_periph;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx, irq;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [3:0] A_DATA = 4'h0;
  localparam logic [3:0] A_STAT = 4'h4;
  localparam logic [3:0] A_DIV  = 4'h8;
  localparam logic [3:0] A_RSV  = 4'hC;

  uart_periph_if bus();

  uart_periph #(.BAUD_DIV(434), .TX_FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got 0x%0h exp 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [3:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd,
                      output int lat);
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.enable    = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_wstrb = ws;
    lat = 0;
    while (lat < 5000) begin
      @(negedge clk);
      lat++;
      if (bus.mem_ready === 1'b1) break;
    end
    if (bus.mem_ready !== 1'b1)
      chk("bus_timeout", {31'd0, bus.mem_ready}, 32'd1);
    rd = bus.mem_rdata;
    bus.mem_valid = 1'b0;
    bus.enable    = 1'b0;
    bus.mem_wstrb = 4'd0;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] d,
                        output int lat);
    xfer(a, 32'd0, 4'd0, d, lat);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat);
    logic [31:0] dummy;
    xfer(a, d, s, dummy, lat);
  endtask

  // Decode one 8N1 frame from uart_tx by mid-bit sampling.
  task automatic get_frame(input int div, output logic [7:0] b,
                           output logic ok, output int t0);
    int n = 0;
    ok = 1'b1;
    b  = 8'd0;
    while (uart_tx !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    if (uart_tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (div / 2) @(negedge clk);
    if (uart_tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (div) @(negedge clk);
    if (uart_tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop,
                         input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = f[i];
      repeat (div - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
  endtask

  logic [31:0] d;
  int          lat;
  logic [7:0]  b1, b2, b3;
  logic [7:0]  tx_q [18];
  logic [7:0]  got_q [18];
  logic        ok_q [18];
  int          t_q [18];
  int          lat_q [18];
  logic [39:0] expv, gotv;
  logic [15:0] div_m;

  initial begin
    bus.mem_valid = 1'b0;
    bus.enable    = 1'b0;
    bus.mem_addr  = 4'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_wstrb = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;

    // Register reads after reset
    rd_reg(A_STAT, d, lat);
    chk("stat_reset", d, 32'h02);
    chk("stat_lat", 32'(lat), 32'd1);
    rd_reg(A_DIV, d, lat);
    chk("div_reset", d, 32'd434);
    div_m = 16'd434;

    // Byte strobe on DIV: only the upper byte changes
    d = $urandom;
    wr_reg(A_DIV, d, 4'b0010, lat);
    div_m[15:8] = d[15:8];
    rd_reg(A_DIV, d, lat);
    chk("div_strobe", d, {16'd0, div_m});
    rd_reg(A_RSV, d, lat);
    chk("rsv_read", d, 32'd0);
    wr_reg(A_RSV, 32'hFFFF_FFFF, 4'hF, lat);
    chk("rsv_wr_lat", 32'(lat), 32'd1);

    // Single TX frame, exact waveform at DIV=4
    wr_reg(A_DIV, 32'd4, 4'b0011, lat);
    for (int k = 0; k < 2; k++) begin
      b1 = (k == 0) ? 8'hA5 : 8'($urandom);
      wr_reg(A_DATA, {24'd0, b1}, 4'b0001, lat);
      lat = 0;
      while (uart_tx !== 1'b0 && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      for (int i = 0; i < 40; i++) begin
        expv[i] = (i < 4) ? 1'b0 : (i >= 36) ? 1'b1 : b1[i / 4 - 1];
        gotv[i] = uart_tx;
        if (i < 39) @(negedge clk);
      end
      chk($sformatf("tx_wave%0d_lo", k), gotv[31:0], expv[31:0]);
      chk($sformatf("tx_wave%0d_hi", k), {24'd0, gotv[39:32]},
          {24'd0, expv[39:32]});
      repeat (2) @(negedge clk);
      rd_reg(A_STAT, d, lat);
      chk("tx_idle_stat", d, 32'h02);
    end

    // 18 writes: FIFO fills, the last write stalls, all go out in order
    foreach (tx_q[k]) tx_q[k] = 8'($urandom);
    fork
      begin
        for (int k = 0; k < 18; k++) begin
          wr_reg(A_DATA, {24'd0, tx_q[k]}, 4'b0001, lat);
          lat_q[k] = lat;
        end
      end
      begin
        for (int k = 0; k < 18; k++)
          get_frame(4, got_q[k], ok_q[k], t_q[k]);
      end
    join
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("burst_byte%0d", k), {24'd0, got_q[k]},
          {24'd0, tx_q[k]});
      chk($sformatf("burst_fmt%0d", k), {31'd0, ok_q[k]}, 32'd1);
      if (k > 0)
        chk($sformatf("burst_gap%0d", k), 32'(t_q[k] - t_q[k-1]), 32'd40);
    end
    chk("burst_lat16", 32'(lat_q[16]), 32'd1);
    chk("burst_stall", {31'd0, lat_q[17] > 1}, 32'd1);
    repeat (4) @(negedge clk);
    rd_reg(A_STAT, d, lat);
    chk("burst_done", d, 32'h02);

    // RX at DIV=8
    wr_reg(A_DIV, 32'd8, 4'b0011, lat);
    b1 = 8'h3C;
    send_rx(b1, 1'b1, 8);
    repeat (4) @(negedge clk);
    chk("rx_irq", {31'd0, irq}, 32'd1);
    rd_reg(A_DATA, d, lat);
    chk("rx_data", d, {23'd0, 1'b1, b1});
    chk("rx_irq_clr", {31'd0, irq}, 32'd0);

    b2 = 8'($urandom);
    b3 = 8'($urandom);
    send_rx(b2, 1'b1, 8);
    send_rx(b3, 1'b1, 8);
    repeat (4) @(negedge clk);
    rd_reg(A_STAT, d, lat);
    chk("ovr_stat", d, 32'h0E);
    rd_reg(A_DATA, d, lat);
    chk("ovr_data", d, {23'd0, 1'b1, b3});
    rd_reg(A_STAT, d, lat);
    chk("ovr_kept", d, 32'h0A);
    wr_reg(A_STAT, 32'd0, 4'b0001, lat);
    rd_reg(A_STAT, d, lat);
    chk("ovr_clr", d, 32'h02);

    // Glitch and framing error
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    rd_reg(A_STAT, d, lat);
    chk("glitch", d, 32'h02);
    send_rx(8'($urandom), 1'b0, 8);
    repeat (20) @(negedge clk);
    rd_reg(A_STAT, d, lat);
    chk("frame_err", d, 32'h02);

    // Reset in the middle of a TX start bit
    wr_reg(A_DIV, 32'd4, 4'b0011, lat);
    wr_reg(A_DATA, {24'd0, 8'($urandom)}, 4'b0001, lat);
    lat = 0;
    while (uart_tx !== 1'b0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("mid_tx_low", {31'd0, uart_tx}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("mid_rst_rdy", {31'd0, bus.mem_ready}, 32'd0);
    reset = 1'b0;
    rd_reg(A_STAT, d, lat);
    chk("mid_rst_stat", d, 32'h02);
    rd_reg(A_DIV, d, lat);
    chk("mid_rst_div", d, 32'd434);
    repeat (20) @(negedge clk);
    chk("mid_rst_idle", {31'd0, uart_tx}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
